// File: rtl/demux4_stream_if.sv
// demux4_stream_if: producer-side and consumer-side stream signals of the
// 1-to-4 demultiplexer. The block side uses the slave modport; the
// environment (producer plus four consumers) uses the master modport.
interface demux4_stream_if;
   logic [3:0] din;
   logic       s1;
   logic       s2;
   logic       bcast;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] a;
   logic [3:0] b;
   logic [3:0] c;
   logic [3:0] d;
   logic       a_valid;
   logic       b_valid;
   logic       c_valid;
   logic       d_valid;
   logic       a_ready;
   logic       b_ready;
   logic       c_ready;
   logic       d_ready;
   logic [7:0] cnt;

   modport master (
      output din, s1, s2, bcast, in_valid,
      output a_ready, b_ready, c_ready, d_ready,
      input  in_ready,
      input  a, b, c, d,
      input  a_valid, b_valid, c_valid, d_valid,
      input  cnt
   );

   modport slave (
      input  din, s1, s2, bcast, in_valid,
      input  a_ready, b_ready, c_ready, d_ready,
      output in_ready,
      output a, b, c, d,
      output a_valid, b_valid, c_valid, d_valid,
      output cnt
   );
endinterface

// File: rtl/demux4_stream.sv
// demux4_stream: registered 1-to-4 demultiplexer for 4-bit words. Each
// channel owns a single-entry slot with its own valid/ready handshake, so a
// stalled consumer only blocks words aimed at its own channel. Broadcast
// loads all four slots at once, and only when every slot can take the word.
// Optional feature: define DEMUX4_STREAM_CNT_EN to build the 8-bit
// accepted-word counter; otherwise cnt is tied to zero.
module demux4_stream (
   input  logic               clk,
   input  logic               rst,
   demux4_stream_if.slave     bus
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } slot_state_t;

   slot_state_t state_q [4];
   logic [3:0]  data_q  [4];

   logic [3:0] ready_vec;
   logic [3:0] can_load;
   logic [3:0] target;
   logic [1:0] sel;
   logic       accept;

   // Combinational acceptance: which slots can take a word this cycle and
   // whether the offered word (single channel or broadcast) fits.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no
      // path through the block leaves it unassigned and a latch is inferred.
      can_load = '0;
      target   = '0;
      ready_vec = {bus.d_ready, bus.c_ready, bus.b_ready, bus.a_ready};
      sel       = {bus.s2, bus.s1};
      for (int i = 0; i < 4; i++) begin
         // A full slot whose consumer drains this cycle can be replaced.
         can_load[i] = (state_q[i] == EMPTY) || ready_vec[i];
      end
      if (bus.bcast) begin
         target      = 4'hf;
         bus.in_ready = &can_load;
      end else begin
         target[sel]  = 1'b1;
         bus.in_ready = can_load[sel];
      end
      accept = bus.in_valid && bus.in_ready;
   end

   // Per-slot FSM and data: load wins over drain, drain alone empties.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            state_q[i] <= EMPTY;
            // NOTE: the slot data is explicitly cleared because its reset value
            // is observable on the a..d outputs, not only the valid flags.
            data_q[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (accept && target[i]) begin
               state_q[i] <= FULL;
               data_q[i]  <= bus.din;
            end else if (state_q[i] == FULL && ready_vec[i]) begin
               state_q[i] <= EMPTY;
            end
         end
      end
   end

   assign bus.a       = data_q[0];
   assign bus.b       = data_q[1];
   assign bus.c       = data_q[2];
   assign bus.d       = data_q[3];
   assign bus.a_valid = (state_q[0] == FULL);
   assign bus.b_valid = (state_q[1] == FULL);
   assign bus.c_valid = (state_q[2] == FULL);
   assign bus.d_valid = (state_q[3] == FULL);

`ifdef DEMUX4_STREAM_CNT_EN
   logic [7:0] cnt_q;

   // Accepted-word counter; a broadcast is one word, wraps naturally at 255.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (accept) begin
         cnt_q <= cnt_q + 8'd1;
      end
   end

   assign bus.cnt = cnt_q;
`else
   assign bus.cnt = '0;
`endif

endmodule

// File: tb/tb_demux4_stream.sv
// tb_demux4_stream: directed scenarios followed by random traffic, all
// checked every cycle against a behavioural model that treats each channel as
// a one-word buffer (occupancy count plus last word written).
module tb_demux4_stream;
   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   demux4_stream_if bus ();

   demux4_stream dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model state.
   int         occ  [4];
   logic [3:0] held [4];
   int         cnt_model;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [3:0] dut_data(input int ch);
      case (ch)
         0:       return bus.a;
         1:       return bus.b;
         2:       return bus.c;
         default: return bus.d;
      endcase
   endfunction

   function automatic logic dut_valid(input int ch);
      case (ch)
         0:       return bus.a_valid;
         1:       return bus.b_valid;
         2:       return bus.c_valid;
         default: return bus.d_valid;
      endcase
   endfunction

   task automatic drive(input logic v, input logic [3:0] w, input int sel,
                        input logic bc, input logic [3:0] rdy, input logic r);
      bus.in_valid = v;
      bus.din      = w;
      bus.s1       = sel[0];
      bus.s2       = sel[1];
      bus.bcast    = bc;
      bus.a_ready  = rdy[0];
      bus.b_ready  = rdy[1];
      bus.c_ready  = rdy[2];
      bus.d_ready  = rdy[3];
      rst          = r;
   endtask

   // One clock cycle: check in_ready against the model, clock the DUT,
   // advance the model, then check every output.
   task automatic step();
      logic [3:0] rdy;
      logic [3:0] room;
      logic       exp_ready;
      logic [7:0] exp_cnt;
      int         sel;
      #1;
      rdy = {bus.d_ready, bus.c_ready, bus.b_ready, bus.a_ready};
      sel = 2 * int'(bus.s2) + int'(bus.s1);
      for (int ch = 0; ch < 4; ch++) room[ch] = (occ[ch] == 0) || rdy[ch];
      exp_ready = bus.bcast ? (room == 4'hf) : room[sel];
      check("in_ready", {7'd0, bus.in_ready}, {7'd0, exp_ready});
      @(posedge clk);
      #1;
      if (rst) begin
         for (int ch = 0; ch < 4; ch++) begin
            occ[ch]  = 0;
            held[ch] = 4'h0;
         end
         cnt_model = 0;
      end else begin
         for (int ch = 0; ch < 4; ch++)
            if (occ[ch] > 0 && rdy[ch]) occ[ch]--;
         if (bus.in_valid && exp_ready) begin
            for (int ch = 0; ch < 4; ch++) begin
               if (bus.bcast || ch == sel) begin
                  occ[ch]++;
                  held[ch] = bus.din;
               end
            end
            cnt_model = (cnt_model + 1) % 256;
         end
      end
      for (int ch = 0; ch < 4; ch++) begin
         check($sformatf("data%0d", ch), {4'd0, dut_data(ch)}, {4'd0, held[ch]});
         check($sformatf("valid%0d", ch), {7'd0, dut_valid(ch)}, {7'd0, occ[ch] > 0});
      end
`ifdef DEMUX4_STREAM_CNT_EN
      exp_cnt = 8'(cnt_model);
`else
      exp_cnt = 8'd0;
`endif
      check("cnt", bus.cnt, exp_cnt);
   endtask

   initial begin
      for (int ch = 0; ch < 4; ch++) begin
         occ[ch]  = 0;
         held[ch] = 4'h0;
      end
      cnt_model = 0;

      // Reset with a word offered: it must be discarded.
      drive(1'b1, 4'h9, 0, 1'b0, 4'hf, 1'b1);
      step();
      step();

      // One word per channel on consecutive edges, consumers always ready.
      drive(1'b1, 4'h0, 0, 1'b0, 4'hf, 1'b0); step();
      drive(1'b1, 4'h5, 1, 1'b0, 4'hf, 1'b0); step();
      drive(1'b1, 4'ha, 2, 1'b0, 4'hf, 1'b0); step();
      drive(1'b1, 4'hf, 3, 1'b0, 4'hf, 1'b0); step();
      drive(1'b0, 4'h0, 0, 1'b0, 4'hf, 1'b0); step();

      // b stalled: first word loads, second waits; c proceeds meanwhile.
      drive(1'b1, 4'h5, 1, 1'b0, 4'b1001, 1'b0); step();
      drive(1'b1, 4'h5, 1, 1'b0, 4'b1001, 1'b0); step();
      drive(1'b1, 4'ha, 2, 1'b0, 4'b1001, 1'b0); step();
      drive(1'b1, 4'h6, 1, 1'b0, 4'b1001, 1'b0); step();
      // b drains and reloads on the same edge.
      drive(1'b1, 4'h6, 1, 1'b0, 4'b1011, 1'b0); step();
      drive(1'b0, 4'h0, 0, 1'b0, 4'b0000, 1'b0); step();

      // Broadcast blocked by a full, stalled d, then released.
      drive(1'b1, 4'h3, 3, 1'b0, 4'b0000, 1'b0); step();
      drive(1'b1, 4'hf, 0, 1'b1, 4'b0000, 1'b0); step();
      drive(1'b1, 4'hf, 2, 1'b1, 4'b0111, 1'b0); step();
      drive(1'b1, 4'hf, 1, 1'b1, 4'b1111, 1'b0); step();

      // Fill all slots, then reset while a word is offered.
      drive(1'b1, 4'h7, 0, 1'b1, 4'b1111, 1'b0); step();
      drive(1'b1, 4'h8, 0, 1'b0, 4'b0000, 1'b1); step();
      drive(1'b0, 4'h0, 0, 1'b0, 4'b0000, 1'b0); step();

      // 256 accepted words on channel a: counter wraps back to its start.
      for (int i = 0; i < 256; i++) begin
         drive(1'b1, 4'($urandom), 0, 1'b0, 4'b0001, 1'b0);
         step();
      end

      // Random traffic with occasional broadcast and reset.
      for (int i = 0; i < 600; i++) begin
         drive(1'($urandom), 4'($urandom), int'($urandom_range(0, 3)),
               ($urandom_range(0, 7) == 0), 4'($urandom),
               ($urandom_range(0, 49) == 0));
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
